// File: rtl/fb_rect_fill.sv
// -----------------------------------------------------------------------------
// fb_rect_fill
//
// AXI4 write master that fills a rectangle of the XGA framebuffer with a solid
// colour, one 16-beat INCR burst (32 pixels, 128 bytes) at a time. Each 64-bit
// beat carries two pixels in the display unpack format:
//   WDATA = {8'h00, pixel, 8'h00, pixel}.
//
// Ports
//   ACLK, ARST            clock, asynchronous active-high reset
//   START                 one-cycle request, only honoured while idle
//   FBADDR                framebuffer base address bits [31:12]
//   X0, Y0                top-left corner (X0[4:0] ignored)
//   WIDTH, HEIGHT         rectangle size (WIDTH[4:0] ignored)
//   COLOR                 fill colour {R,G,B}
//   COLOR2                second checkerboard colour (checker build only)
//   BUSY, DONE, ERR       status: busy, one-cycle completion, sticky BRESP error
//   M_AXI_AW*/W*/B*       AXI4 write channels (AW fields and WSTRB constant)
//
// Build option
//   FB_FILL_CHECKER_EN    when defined, adds COLOR2 and alternates COLOR/COLOR2
//                         on a 32x32 pixel checkerboard.
// -----------------------------------------------------------------------------
module fb_rect_fill #(
    parameter int unsigned STRIDE_BYTES = 4096,
    parameter int unsigned H_RES        = 1024,
    parameter int unsigned V_RES        = 768
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic        START,
    input  logic [19:0] FBADDR,
    input  logic [10:0] X0,
    input  logic [9:0]  Y0,
    input  logic [10:0] WIDTH,
    input  logic [9:0]  HEIGHT,
    input  logic [23:0] COLOR,
`ifdef FB_FILL_CHECKER_EN
    input  logic [23:0] COLOR2,
`endif
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_AWADDR,
    output logic [7:0]  M_AXI_AWLEN,
    output logic [2:0]  M_AXI_AWSIZE,
    output logic [1:0]  M_AXI_AWBURST,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    output logic [63:0] M_AXI_WDATA,
    output logic [7:0]  M_AXI_WSTRB,
    output logic        M_AXI_WLAST,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    input  logic [1:0]  M_AXI_BRESP
);

    // TURN is the one-cycle gap after the B handshake where the updated x/y
    // position is compared against the clip limits.
    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_TURN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [19:0] fb_q, fb_d;
    logic [10:0] x0_q, x0_d, xe_q, xe_d, x_q, x_d;
    logic [9:0]  ye_q, ye_d, y_q, y_d;
    logic [23:0] color_q, color_d;
    logic [3:0]  beat_q, beat_d;
    logic        err_q, err_d;
`ifdef FB_FILL_CHECKER_EN
    logic [23:0] color2_q, color2_d;
`endif

    // Clip limits, computed one bit wider than the operands so the sums
    // cannot wrap before the comparison against the screen size.
    logic [10:0] x0_al, w_al, xe_clip;
    logic [11:0] x_sum;
    logic [10:0] y_sum;
    logic [9:0]  ye_clip;
    logic        rect_empty;
    logic        unused_low_bits;

    assign x0_al      = {X0[10:5], 5'd0};
    assign w_al       = {WIDTH[10:5], 5'd0};
    assign x_sum      = {1'b0, x0_al} + {1'b0, w_al};
    assign y_sum      = {1'b0, Y0} + {1'b0, HEIGHT};
    assign xe_clip    = (x_sum > 12'(H_RES)) ? 11'(H_RES) : x_sum[10:0];
    assign ye_clip    = (y_sum > 11'(V_RES)) ? 10'(V_RES) : y_sum[9:0];
    assign rect_empty = (w_al == 11'd0) || (HEIGHT == 10'd0) ||
                        ({1'b0, x0_al} >= 12'(H_RES)) || ({1'b0, Y0} >= 11'(V_RES));
    // Sub-burst bits of X0/WIDTH carry no meaning for a 32-pixel-aligned fill.
    assign unused_low_bits = ^{X0[4:0], WIDTH[4:0]};

    // Position step after each completed burst.
    logic [10:0] x_inc;
    logic [9:0]  y_inc;
    logic        row_wrap;

    assign x_inc    = x_q + 11'd32;
    assign y_inc    = y_q + 10'd1;
    assign row_wrap = (x_inc >= xe_q);

    // State register.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers
            // sample the same pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: a default ahead of the case guarantees every path assigns
        // state_d, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = rect_empty ? S_DONE : S_AW;
            S_AW:    if (M_AXI_AWREADY) state_d = S_W;
            S_W:     if (M_AXI_WREADY && (beat_q == 4'd15)) state_d = S_B;
            S_B:     if (M_AXI_BVALID) state_d = S_TURN;
            S_TURN:  state_d = (y_q >= ye_q) ? S_DONE : S_AW;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; all handshake/status outputs depend on state only, so
    // they drop together as soon as ARST forces the state back to IDLE.
    always_comb begin
        BUSY          = 1'b0;
        DONE          = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_WLAST   = 1'b0;
        M_AXI_BREADY  = 1'b0;
        case (state_q)
            S_AW: begin
                BUSY          = 1'b1;
                M_AXI_AWVALID = 1'b1;
            end
            S_W: begin
                BUSY         = 1'b1;
                M_AXI_WVALID = 1'b1;
                M_AXI_WLAST  = (beat_q == 4'd15);
            end
            S_B: begin
                BUSY         = 1'b1;
                M_AXI_BREADY = 1'b1;
            end
            S_TURN:  BUSY = 1'b1;
            S_DONE:  DONE = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: latch the request, count beats, walk the rectangle.
    always_comb begin
        fb_d    = fb_q;
        x0_d    = x0_q;
        xe_d    = xe_q;
        ye_d    = ye_q;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        beat_d  = beat_q;
        err_d   = err_q;
`ifdef FB_FILL_CHECKER_EN
        color2_d = color2_q;
`endif
        if ((state_q == S_IDLE) && START) begin
            fb_d    = FBADDR;
            x0_d    = x0_al;
            x_d     = x0_al;
            y_d     = Y0;
            xe_d    = xe_clip;
            ye_d    = ye_clip;
            color_d = COLOR;
            beat_d  = 4'd0;
            err_d   = 1'b0;
`ifdef FB_FILL_CHECKER_EN
            color2_d = COLOR2;
`endif
        end
        // The 4-bit counter wraps 15 -> 0, so it is ready for the next burst.
        if ((state_q == S_W) && M_AXI_WREADY) begin
            beat_d = beat_q + 4'd1;
        end
        // Errors are recorded but never stop the fill.
        if ((state_q == S_B) && M_AXI_BVALID) begin
            err_d = err_q | (M_AXI_BRESP != 2'b00);
            if (row_wrap) begin
                x_d = x0_q;
                y_d = y_inc;
            end else begin
                x_d = x_inc;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            fb_q    <= '0;
            x0_q    <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
`ifdef FB_FILL_CHECKER_EN
            color2_q <= '0;
`endif
        end else begin
            fb_q    <= fb_d;
            x0_q    <= x0_d;
            xe_q    <= xe_d;
            ye_q    <= ye_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
`ifdef FB_FILL_CHECKER_EN
            color2_q <= color2_d;
`endif
        end
    end

    // Burst colour.
    logic [23:0] pix;
`ifdef FB_FILL_CHECKER_EN
    assign pix = (x_q[5] ^ y_q[5]) ? color2_q : color_q;
`else
    assign pix = color_q;
`endif

    // x_q/y_q only change in B, so AWADDR is stable for the whole AW phase.
    assign M_AXI_AWADDR  = {fb_q, 12'h000} + (32'(y_q) * STRIDE_BYTES) + {19'd0, x_q, 2'b00};
    assign M_AXI_AWLEN   = 8'd15;
    assign M_AXI_AWSIZE  = 3'd3;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_WDATA   = {8'h00, pix, 8'h00, pix};
    assign M_AXI_WSTRB   = 8'hFF;
    assign ERR           = err_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// -----------------------------------------------------------------------------
// tb_fb_rect_fill
//
// Scoreboard bench for fb_rect_fill. Each command is expanded by a reference
// model (nested loops over the clipped rectangle) into expected bursts and a
// completion record; a monitor compares every AW/W handshake and DONE pulse
// against those queues. A small AXI slave supplies AWREADY stalls, random
// WREADY and scripted BRESP values.
// -----------------------------------------------------------------------------
module tb_fb_rect_fill;

    localparam int H_RES  = 1024;
    localparam int V_RES  = 768;
    localparam int STRIDE = 4096;

    logic        ACLK, ARST, START;
    logic [19:0] FBADDR;
    logic [10:0] X0, WIDTH;
    logic [9:0]  Y0, HEIGHT;
    logic [23:0] COLOR;
`ifdef FB_FILL_CHECKER_EN
    logic [23:0] COLOR2;
`endif
    logic        BUSY, DONE, ERR;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic        M_AXI_WVALID, M_AXI_WREADY;
    logic [63:0] M_AXI_WDATA;
    logic [7:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST;
    logic        M_AXI_BVALID, M_AXI_BREADY;
    logic [1:0]  M_AXI_BRESP;

    fb_rect_fill dut (
        .ACLK(ACLK), .ARST(ARST), .START(START), .FBADDR(FBADDR),
        .X0(X0), .Y0(Y0), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .COLOR(COLOR),
`ifdef FB_FILL_CHECKER_EN
        .COLOR2(COLOR2),
`endif
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    typedef struct { logic [31:0] addr; logic [63:0] data; } burst_t;
    typedef struct { int n; logic err; } done_t;

    burst_t     exp_q[$];
    done_t      done_q[$];
    logic [1:0] bresp_q[$];

    int checks = 0;
    int errors = 0;

    // Slave behaviour knobs.
    int aw_stall_cfg = 0;
    bit w_rand = 1'b0;
    bit lat_check = 1'b0;
    logic [23:0] color2_v = 24'h0;

    // Monitor state visible to stimulus.
    int mon_beat = 0;
    int done_cnt = 0;
    bit aw_open = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    // Model a command, queue its expectations, then pulse START.
    task automatic issue(input logic [19:0] fb, input int x0, input int y0, input int w,
                         input int h, input logic [23:0] color, input int bad_idx,
                         input bit rand_err);
        int xa, wa, xe, ye, n;
        logic err;
        burst_t b;
        logic [23:0] p;
        logic [1:0] br;
        logic [31:0] base;
        xa   = x0 - (x0 % 32);
        wa   = w - (w % 32);
        xe   = (xa + wa < H_RES) ? xa + wa : H_RES;
        ye   = (y0 + h < V_RES) ? y0 + h : V_RES;
        base = {fb, 12'h000};
        n    = 0;
        err  = 1'b0;
        for (int y = y0; y < ye; y++) begin
            for (int x = xa; x < xe; x += 32) begin
                p = color;
`ifdef FB_FILL_CHECKER_EN
                if ((((x / 32) + (y / 32)) % 2) == 1) p = color2_v;
`endif
                b.addr = base + 32'(y * STRIDE + x * 4);
                b.data = {8'h00, p, 8'h00, p};
                exp_q.push_back(b);
                if (n == bad_idx) br = 2'b10;
                else if (rand_err && ($urandom_range(0, 7) == 0)) br = 2'b11;
                else br = 2'b00;
                bresp_q.push_back(br);
                err = err | (br != 2'b00);
                n++;
            end
        end
        done_q.push_back('{n: n, err: err});

        @(posedge ACLK);
        #1;
        FBADDR = fb;
        X0     = 11'(x0);
        Y0     = 10'(y0);
        WIDTH  = 11'(w);
        HEIGHT = 10'(h);
        COLOR  = color;
`ifdef FB_FILL_CHECKER_EN
        COLOR2 = color2_v;
`endif
        START  = 1'b1;
        @(posedge ACLK);
        #1;
        START = 1'b0;
        check("err_cleared_on_start", ERR, 0);
        check("busy_after_start", BUSY, (n > 0));
        check("awvalid_after_start", M_AXI_AWVALID, (n > 0));
        // Scramble the request inputs to prove they were latched.
        FBADDR = 20'($urandom);
        X0     = 11'($urandom);
        Y0     = 10'($urandom);
        WIDTH  = 11'($urandom);
        HEIGHT = 10'($urandom);
        COLOR  = 24'($urandom);
    endtask

    task automatic wait_done();
        int  start_cnt;
        bit  got;
        start_cnt = done_cnt;
        got = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge ACLK);
            #2;
            if (done_cnt != start_cnt) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no DONE, expected DONE within 20000 cycles");
        end
    endtask

    // AXI slave: decide at the negedge what handshakes complete at the next
    // posedge, then update the ready/response signals just after that edge.
    initial begin : slave
        int stall_cnt;
        bit aw_hs_s, w_last_s, b_hs_s;
        stall_cnt = 0;
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        M_AXI_BVALID  = 1'b0;
        M_AXI_BRESP   = 2'b00;
        forever begin
            @(negedge ACLK);
            aw_hs_s  = M_AXI_AWVALID && M_AXI_AWREADY;
            w_last_s = M_AXI_WVALID && M_AXI_WREADY && M_AXI_WLAST;
            b_hs_s   = M_AXI_BVALID && M_AXI_BREADY;
            @(posedge ACLK);
            #1;
            if (ARST) begin
                M_AXI_BVALID  = 1'b0;
                M_AXI_BRESP   = 2'b00;
                M_AXI_AWREADY = 1'b1;
                M_AXI_WREADY  = 1'b1;
                stall_cnt     = 0;
            end else begin
                if (aw_hs_s) stall_cnt = 0;
                if (M_AXI_AWVALID && (stall_cnt < aw_stall_cfg)) begin
                    M_AXI_AWREADY = 1'b0;
                    stall_cnt++;
                end else begin
                    M_AXI_AWREADY = 1'b1;
                end
                M_AXI_WREADY = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                if (b_hs_s) begin
                    M_AXI_BVALID = 1'b0;
                    M_AXI_BRESP  = 2'b00;
                end
                if (w_last_s) begin
                    M_AXI_BVALID = 1'b1;
                    if (bresp_q.size() > 0) M_AXI_BRESP = bresp_q.pop_front();
                    else M_AXI_BRESP = 2'b00;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        burst_t      cur;
        done_t       d;
        int          cycle, last_aw_cycle, bursts_seen;
        bit          aw_pend;
        logic [31:0] aw_pend_addr;
        cycle = 0;
        last_aw_cycle = 0;
        bursts_seen = 0;
        aw_pend = 1'b0;
        aw_pend_addr = '0;
        cur = '{addr: '0, data: '0};
        forever begin
            @(negedge ACLK);
            cycle++;
            if (ARST) begin
                aw_open = 1'b0;
                aw_pend = 1'b0;
                mon_beat = 0;
                bursts_seen = 0;
            end else begin
                if (aw_pend) begin
                    check("awvalid_held", M_AXI_AWVALID, 1);
                    check("awaddr_stable", M_AXI_AWADDR, aw_pend_addr);
                end
                if (M_AXI_WVALID) check("wvalid_after_aw", aw_open, 1);
                if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_aw", M_AXI_AWADDR);
                    end else begin
                        cur = exp_q.pop_front();
                        check("awaddr", M_AXI_AWADDR, cur.addr);
                    end
                    check("awlen", M_AXI_AWLEN, 15);
                    check("awsize", M_AXI_AWSIZE, 3);
                    check("awburst", M_AXI_AWBURST, 1);
                    aw_open = 1'b1;
                    mon_beat = 0;
                    last_aw_cycle = cycle;
                    bursts_seen++;
                end
                aw_pend = M_AXI_AWVALID && !M_AXI_AWREADY;
                aw_pend_addr = M_AXI_AWADDR;
                if (M_AXI_WVALID && M_AXI_WREADY) begin
                    check("wdata", M_AXI_WDATA, cur.data);
                    check("wlast", M_AXI_WLAST, (mon_beat == 15));
                    check("wstrb", M_AXI_WSTRB, 8'hFF);
                    mon_beat++;
                    if (M_AXI_WLAST) aw_open = 1'b0;
                end
                if (DONE) begin
                    if (done_q.size() == 0) begin
                        fail_now("unexpected_done", {63'd0, DONE});
                    end else begin
                        d = done_q.pop_front();
                        check("burst_count", bursts_seen, d.n);
                        check("err_at_done", ERR, d.err);
                        check("pending_bursts", exp_q.size(), 0);
                    end
                    check("busy_at_done", BUSY, 0);
                    if (lat_check) check("done_latency", cycle - last_aw_cycle, 19);
                    bursts_seen = 0;
                    done_cnt++;
                end
            end
        end
    end

    initial begin : stimulus
        logic [19:0] fb;
        bit          got;
        ARST   = 1'b1;
        START  = 1'b0;
        FBADDR = '0;
        X0     = '0;
        Y0     = '0;
        WIDTH  = '0;
        HEIGHT = '0;
        COLOR  = '0;
`ifdef FB_FILL_CHECKER_EN
        COLOR2   = '0;
        color2_v = 24'hA5C3E1;
`endif
        fb = 20'h10000;

        // Reset state.
        repeat (3) @(negedge ACLK);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_err", ERR, 0);
        check("rst_awvalid", M_AXI_AWVALID, 0);
        check("rst_wvalid", M_AXI_WVALID, 0);
        check("rst_wlast", M_AXI_WLAST, 0);
        check("rst_bready", M_AXI_BREADY, 0);
        check("rst_awaddr", M_AXI_AWADDR, 0);
        check("rst_wdata", M_AXI_WDATA, 0);
        check("rst_awlen", M_AXI_AWLEN, 15);
        check("rst_awsize", M_AXI_AWSIZE, 3);
        check("rst_awburst", M_AXI_AWBURST, 1);
        check("rst_wstrb", M_AXI_WSTRB, 8'hFF);
        #2 ARST = 1'b0;

        // Single burst, ready signals high, latency measured.
        lat_check = 1'b1;
        issue(fb, 0, 0, 32, 1, 24'h123456, -1, 1'b0);
        wait_done();
        lat_check = 1'b0;

        // 2x2 bursts, back-to-back with the previous DONE.
        issue(fb, 64, 2, 64, 2, 24'hABCDEF, -1, 1'b0);
        wait_done();

        // Clipped at right and bottom edges.
        issue(fb, 1000, 767, 96, 5, 24'h00FF00, -1, 1'b0);
        wait_done();

        // Empty rectangles and extreme widths.
        issue(fb, 0, 0, 31, 3, 24'h111111, -1, 1'b0);
        wait_done();
        issue(fb, 1024, 0, 64, 1, 24'h222222, -1, 1'b0);
        wait_done();
        issue(fb, 0, 768, 64, 1, 24'h333333, -1, 1'b0);
        wait_done();
        issue(fb, 0, 0, 64, 0, 24'h444444, -1, 1'b0);
        wait_done();
        issue(fb, 992, 100, 2047, 1, 24'h555555, -1, 1'b0);
        wait_done();
        issue(fb, 0, 766, 32, 1023, 24'h666666, -1, 1'b0);
        wait_done();

        // AWREADY stalls, random WREADY, START while busy must be ignored.
        aw_stall_cfg = 10;
        w_rand = 1'b1;
        issue(fb, 128, 40, 32, 1, 24'h0F0F0F, -1, 1'b0);
        repeat (4) @(posedge ACLK);
        #1;
        X0 = 11'd0;
        Y0 = 10'd0;
        WIDTH = 11'd256;
        HEIGHT = 10'd4;
        START = 1'b1;
        @(posedge ACLK);
        #1;
        START = 1'b0;
        wait_done();
        aw_stall_cfg = 0;
        w_rand = 1'b0;

        // SLVERR on the middle of three bursts, then ERR clears on next START.
        issue(fb, 0, 5, 96, 1, 24'h808080, 1, 1'b0);
        wait_done();
        issue(fb, 0, 6, 32, 1, 24'h909090, -1, 1'b0);
        wait_done();

        // Asynchronous reset in the middle of beat 7.
        issue(fb, 0, 10, 64, 1, 24'hC0FFEE, -1, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge ACLK);
            #1;
            if (aw_open && (mon_beat == 7)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL beat7_timeout: got beat %0d, expected to reach beat 7", mon_beat);
        end
        #1 ARST = 1'b1;
        #1;
        check("arst_busy", BUSY, 0);
        check("arst_awvalid", M_AXI_AWVALID, 0);
        check("arst_wvalid", M_AXI_WVALID, 0);
        check("arst_bready", M_AXI_BREADY, 0);
        exp_q.delete();
        done_q.delete();
        bresp_q.delete();
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        #2 ARST = 1'b0;
        issue(fb, 0, 10, 64, 1, 24'hC0FFEE, -1, 1'b0);
        wait_done();

        // Randomised commands with random stalls and error responses.
        for (int k = 0; k < 25; k++) begin
            int rx, ry, rw, rh;
            aw_stall_cfg = $urandom_range(0, 3);
            w_rand = 1'($urandom_range(0, 1));
`ifdef FB_FILL_CHECKER_EN
            color2_v = 24'($urandom);
`endif
            rx = $urandom_range(0, 1100);
            ry = ($urandom_range(0, 3) == 0) ? $urandom_range(760, 800) : $urandom_range(0, 767);
            rw = $urandom_range(0, 200);
            rh = $urandom_range(0, 4);
            issue(20'($urandom), rx, ry, rw, rh, 24'($urandom), -1, 1'b1);
            wait_done();
        end

        repeat (5) @(posedge ACLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
